// File: rtl/div_unit.sv
// Iterative 32-bit integer divider: one radix-2 restoring step per cycle, 34-cycle latency.
// Handles DIV/DIVU/REM/REMU, including divide-by-zero and signed overflow.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        Flush,
  input  logic [1:0]  DivType,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] DivOut
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] div_q, div_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        accept;
  logic        last_iter;
  logic        in_signed;
  logic [31:0] mag1, mag2;
  logic [32:0] shifted, trial;
  logic        fix_signed, fix_rem;
  logic [31:0] q_fix, r_fix, fix_result;

  assign accept    = (state_q == StIdle) && Start && !Flush;
  assign last_iter = (cnt_q == 5'd31);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Flush overrides everything
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (Start) state_d = StCalc;
        StCalc:  if (last_iter) state_d = StFix;
        StFix:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    Busy = (state_q != StIdle);
    Done = (state_q == StDone);
  end

  assign DivOut = res_q;

  // Magnitudes of the incoming operands; 0x80000000 maps to unsigned 2^31
  always_comb begin
    in_signed = ~DivType[0];
    mag1      = (in_signed && Operand1[31]) ? -Operand1 : Operand1;
    mag2      = (in_signed && Operand2[31]) ? -Operand2 : Operand2;
  end

  // Remainder stays below the divisor, so 32 bits hold it; the shifted value needs 33
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, div_q};
  end

  always_comb begin
    fix_signed = ~type_q[0];
    fix_rem    = type_q[1];
    q_fix      = (fix_signed && (op1_q[31] ^ op2_q[31])) ? -quo_q : quo_q;
    r_fix      = (fix_signed && op1_q[31]) ? -rem_q : rem_q;
    if (op2_q == 32'd0) begin
      fix_result = fix_rem ? op1_q : 32'hFFFF_FFFF;
    end else if (fix_signed && (op1_q == 32'h8000_0000) && (op2_q == 32'hFFFF_FFFF)) begin
      fix_result = fix_rem ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      fix_result = fix_rem ? r_fix : q_fix;
    end
  end

  always_comb begin
    op1_d  = op1_q;
    op2_d  = op2_q;
    type_d = type_q;
    div_d  = div_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    if (accept) begin
      op1_d  = Operand1;
      op2_d  = Operand2;
      type_d = DivType;
      div_d  = mag2;
      quo_d  = mag1;
      rem_d  = 32'd0;
      cnt_d  = 5'd0;
    end else if ((state_q == StCalc) && !Flush) begin
      cnt_d = cnt_q + 5'd1;
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end else if ((state_q == StFix) && !Flush) begin
      res_d = fix_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= 32'd0;
      op2_q  <= 32'd0;
      type_q <= 2'd0;
      div_q  <= 32'd0;
      quo_q  <= 32'd0;
      rem_q  <= 32'd0;
      res_q  <= 32'd0;
      cnt_q  <= 5'd0;
    end else begin
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      type_q <= type_d;
      div_q  <= div_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results and Done cycles are queued at issue time
// and checked when Done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  DivType = 2'd0;
  logic [31:0] Operand1 = 32'd0;
  logic [31:0] Operand2 = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] DivOut;

  div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .Flush    (Flush),
    .DivType  (DivType),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Busy     (Busy),
    .Done     (Done),
    .DivOut   (DivOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] t, input logic [31:0] a,
                                        input logic [31:0] b);
    int   sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (t)
      2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", {31'b0, Done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("result", DivOut, e.res);
        check_val("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit track, output int acc);
    @(negedge clk);
    DivType  = t;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    acc   = cyc;
    if (track) begin
      sb_q.push_back('{res: exp, due: cyc + 33});
      last_exp = exp;
    end
    // Scramble inputs: latched operands must not care
    DivType  = 2'($urandom);
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    logic [1:0]  rt;
    logic [31:0] ra, rb;

    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'd7,          32'hFFFF_FFFF, 32'd7});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{2'b00, 32'h1234_5678, 32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'h1234_5678, 32'd0,          32'h1234_5678});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'd3,          32'hFFFF_FFFE});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'd2,          32'hC000_0000});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'd2,          32'h4000_0000});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14});

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'b0, Busy}, 32'd0);
    check_val("rst_done", {31'b0, Done}, 32'd0);
    check_val("rst_divout", DivOut, 32'd0);
    rst_n = 1'b1;

    // DIV -7 / 2 with Busy window checks
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, a0);
    check_val("busy_c1", {31'b0, Busy}, 32'd1);
    repeat (33) @(negedge clk);
    check_val("busy_c34", {31'b0, Busy}, 32'd1);
    @(negedge clk);
    check_val("busy_c35", {31'b0, Busy}, 32'd0);
    drain();

    foreach (vecs[i]) begin
      issue(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, a0);
      drain();
    end

    for (int i = 0; i < 8; i++) begin
      rt = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      issue(rt, ra, rb, model(rt, ra, rb), 1'b1, a0);
      drain();
    end

    // Flush at cycle 10
    issue(2'b01, 32'd55, 32'd5, 32'd0, 1'b0, a0);
    repeat (8) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check_val("flush_busy", {31'b0, Busy}, 32'd0);
    check_val("flush_divout", DivOut, last_exp);
    repeat (40) @(negedge clk);
    check_val("flush_divout_hold", DivOut, last_exp);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1, a0);
    drain();

    // Reset at cycle 20
    issue(2'b01, 32'd1000, 32'd3, 32'd0, 1'b0, a0);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_busy", {31'b0, Busy}, 32'd0);
    check_val("rst_mid_done", {31'b0, Done}, 32'd0);
    check_val("rst_mid_divout", DivOut, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_val("rst_divout_hold", DivOut, 32'd0);
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b1, a0);
    drain();

    // Start held across two requests; Operand1 changes during the first
    @(negedge clk);
    DivType  = 2'b01;
    Operand1 = 32'd1000;
    Operand2 = 32'd10;
    Start    = 1'b1;
    @(negedge clk);
    a0 = cyc;
    sb_q.push_back('{res: 32'd100, due: a0 + 33});
    repeat (4) @(negedge clk);
    Operand1 = 32'd5000;
    sb_q.push_back('{res: 32'd500, due: a0 + 68});
    repeat (29) @(negedge clk);
    check_val("b2b_busy_c34", {31'b0, Busy}, 32'd1);
    @(negedge clk);
    check_val("b2b_busy_c35", {31'b0, Busy}, 32'd0);
    @(negedge clk);
    Start = 1'b0;
    check_val("b2b_busy_c36", {31'b0, Busy}, 32'd1);
    drain();

    // Flush wins over Start in IDLE
    @(negedge clk);
    DivType  = 2'b01;
    Operand1 = 32'd9;
    Operand2 = 32'd3;
    Start    = 1'b1;
    Flush    = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    Flush = 1'b0;
    check_val("flush_start_busy", {31'b0, Busy}, 32'd0);
    repeat (40) @(negedge clk);
    check_val("flush_start_divout", DivOut, 32'd500);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
